// File: rtl/circle_pkg.sv
// Shared types and constants for the circle tracer and related lattice walkers.
// Step direction is encoded as the sign of each unit step.
package circle_pkg;

    typedef enum logic [2:0] {StIdle, StEmit, StCalc, StSel, StFin} state_e;

    // Each axis steps by exactly one unit; the flag picks -1 over +1.
    typedef struct packed {
        logic dx_neg;
        logic dy_neg;
    } step_t;

    typedef enum logic [1:0] {CandA, CandB, CandC} cand_e;

    localparam logic Ccw = 1'b0;
    localparam logic Cw  = 1'b1;

    // Earlier entries win when radial errors are equal.
    localparam cand_e TiePrio [3] = '{CandB, CandA, CandC};

    function automatic step_t pick_step(input logic dir, input logic x_gt, input logic x_lt,
                                        input logic y_gt, input logic y_lt);
        step_t s;
        s = '0;
        unique case (dir)
            Cw: begin
                if (y_gt && !x_lt)      s = '{dx_neg: 1'b0, dy_neg: 1'b1};
                else if (x_gt && !y_gt) s = '{dx_neg: 1'b1, dy_neg: 1'b1};
                else if (y_lt && !x_gt) s = '{dx_neg: 1'b1, dy_neg: 1'b0};
                else                    s = '{dx_neg: 1'b0, dy_neg: 1'b0};
            end
            Ccw: begin
                if (x_gt && !y_lt)      s = '{dx_neg: 1'b1, dy_neg: 1'b0};
                else if (!x_gt && y_gt) s = '{dx_neg: 1'b1, dy_neg: 1'b1};
                else if (x_lt && !y_gt) s = '{dx_neg: 1'b0, dy_neg: 1'b1};
                else                    s = '{dx_neg: 1'b0, dy_neg: 1'b0};
            end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/circle_err_calc.sv
// Radial error of the three neighbour candidates A=(x+dx,y), B=(x+dx,y+dy), C=(x,y+dy).
// Purely combinational; ovf flags a stepped coordinate that leaves the W-bit range.
module circle_err_calc
    import circle_pkg::*;
#(
    parameter int unsigned W  = 16,
    parameter int unsigned EW = 2 * W + 2
) (
    input  logic signed [W-1:0]   x,
    input  logic signed [W-1:0]   y,
    input  step_t                 step,
    input  logic        [2*W-1:0] r2,
    output logic signed [W-1:0]   xn,
    output logic signed [W-1:0]   yn,
    output logic signed [EW-1:0]  ea,
    output logic signed [EW-1:0]  eb,
    output logic signed [EW-1:0]  ec,
    output logic                  ovf
);

    localparam logic signed [W:0] One = {{W{1'b0}}, 1'b1};

    logic signed [W:0]    xw, yw, xs, ys;
    logic signed [EW-1:0] r2e, sq_xw, sq_yw, sq_xs, sq_ys;

    function automatic logic signed [EW-1:0] sq(input logic signed [W:0] v);
        logic signed [EW-1:0] ve;
        ve = {{(EW - W - 1){v[W]}}, v};
        return ve * ve;
    endfunction

    always_comb begin
        xw    = {x[W-1], x};
        yw    = {y[W-1], y};
        xs    = step.dx_neg ? xw - One : xw + One;
        ys    = step.dy_neg ? yw - One : yw + One;
        ovf   = (xs[W] != xs[W-1]) || (ys[W] != ys[W-1]);
        xn    = xs[W-1:0];
        yn    = ys[W-1:0];
        r2e   = {{(EW - 2 * W){1'b0}}, r2};
        sq_xw = sq(xw);
        sq_yw = sq(yw);
        sq_xs = sq(xs);
        sq_ys = sq(ys);
        ea    = sq_xs + sq_yw - r2e;
        eb    = sq_xs + sq_ys - r2e;
        ec    = sq_xw + sq_ys - r2e;
    end

endmodule

// File: rtl/circle_tracer.sv
// Walks a full lattice circle from a start point, one minimum-radial-error neighbour per
// step, streaming each point over valid/ready with start/busy/done control.
module circle_tracer
    import circle_pkg::*;
#(
    parameter int unsigned W         = 16,
    parameter int unsigned EW        = 2 * W + 2,
    parameter int unsigned MAX_STEPS = 65535,
    localparam int unsigned CW       = $clog2(MAX_STEPS + 1)
) (
    input  logic                 mclock,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic signed [W-1:0]  x0,
    input  logic signed [W-1:0]  y0,
    input  logic [2*W-1:0]       r2,
    input  logic                 dir,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic signed [W-1:0]  ox,
    output logic signed [W-1:0]  oy,
    output logic                 ovalid,
    input  logic                 oready,
    output logic [CW-1:0]        count
);

    state_e state_q, state_d;

    logic signed [W-1:0]  x_q, y_q, sx_q, sy_q, xa_q, yb_q;
    logic [2*W-1:0]       r2_q;
    logic                 dir_q, err_q, done_q;
    logic [CW-1:0]        count_q;
    logic signed [EW-1:0] ea_q, eb_q, ec_q;

    step_t                step;
    logic signed [W-1:0]  xn, yn, nx, ny;
    logic signed [EW-1:0] ea, eb, ec;
    logic                 ovf, origin, back, at_max, hs;
    logic [EW-1:0]        mag [3];
    cand_e                best;

    function automatic logic [EW-1:0] abs_e(input logic signed [EW-1:0] e);
        return e[EW-1] ? -e : e;
    endfunction

    assign origin = (x0 == '0) && (y0 == '0);
    assign hs     = (state_q == StEmit) && oready;
    assign at_max = (count_q == CW'(MAX_STEPS));
    assign step   = pick_step(dir_q, !x_q[W-1] && (x_q != '0), x_q[W-1],
                              !y_q[W-1] && (y_q != '0), y_q[W-1]);

    circle_err_calc #(
        .W  (W),
        .EW (EW)
    ) u_err_calc (
        .x    (x_q),
        .y    (y_q),
        .step (step),
        .r2   (r2_q),
        .xn   (xn),
        .yn   (yn),
        .ea   (ea),
        .eb   (eb),
        .ec   (ec),
        .ovf  (ovf)
    );

    // Strict compare keeps the earlier-priority candidate on ties.
    always_comb begin
        mag[CandA] = abs_e(ea_q);
        mag[CandB] = abs_e(eb_q);
        mag[CandC] = abs_e(ec_q);
        best = TiePrio[0];
        for (int i = 1; i < 3; i++) begin
            if (mag[TiePrio[i]] < mag[best]) best = TiePrio[i];
        end
        nx = x_q;
        ny = y_q;
        case (best)
            CandA:   begin nx = xa_q; ny = y_q;  end
            CandB:   begin nx = xa_q; ny = yb_q; end
            CandC:   begin nx = x_q;  ny = yb_q; end
            default: begin nx = x_q;  ny = y_q;  end
        endcase
        back = (nx == sx_q) && (ny == sy_q);
    end

    always_ff @(posedge mclock or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = origin ? StFin : StEmit;
            StEmit: if (oready) state_d = StCalc;
            StCalc: state_d = ovf ? StFin : StSel;
            StSel:  state_d = (back || at_max) ? StFin : StEmit;
            StFin:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ovalid = (state_q == StEmit);
        busy   = (state_q != StIdle);
        done   = done_q;
        err    = err_q;
        ox     = x_q;
        oy     = y_q;
        count  = count_q;
    end

    always_ff @(posedge mclock or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            xa_q    <= '0;
            yb_q    <= '0;
            r2_q    <= '0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            ea_q    <= '0;
            eb_q    <= '0;
            ec_q    <= '0;
        end else begin
            done_q <= (state_q == StFin);
            if (state_q == StIdle && start) begin
                x_q     <= x0;
                y_q     <= y0;
                sx_q    <= x0;
                sy_q    <= y0;
                r2_q    <= r2;
                dir_q   <= dir;
                count_q <= '0;
                err_q   <= origin;
            end
            if (hs) count_q <= count_q + CW'(1);
            if (state_q == StCalc) begin
                ea_q <= ea;
                eb_q <= eb;
                ec_q <= ec;
                xa_q <= xn;
                yb_q <= yn;
                if (ovf) err_q <= 1'b1;
            end
            if (state_q == StSel) begin
                x_q <= nx;
                y_q <= ny;
                if (!back && at_max) err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_circle_tracer.sv
// Self-checking bench for circle_tracer: directed vectors, stall/abort/reset sequences and
// randomized traces against a point-list reference model.
module tb_circle_tracer;

    logic               mclock = 1'b0;
    logic               rst_n  = 1'b0;
    logic               start  = 1'b0;
    logic               dir    = 1'b0;
    logic               oready = 1'b0;
    logic signed [15:0] x0     = '0;
    logic signed [15:0] y0     = '0;
    logic [31:0]        r2     = '0;

    logic               busy_a, done_a, err_a, ovalid_a;
    logic signed [15:0] ox_a, oy_a;
    logic [15:0]        count_a;
    logic               busy_b, done_b, err_b, ovalid_b;
    logic signed [15:0] ox_b, oy_b;
    logic [3:0]         count_b;

    logic               use_b = 1'b0;
    logic               m_ovalid, m_done, m_err, m_busy;
    logic signed [15:0] m_ox, m_oy;
    logic [15:0]        m_count;

    assign m_ovalid = use_b ? ovalid_b : ovalid_a;
    assign m_done   = use_b ? done_b : done_a;
    assign m_err    = use_b ? err_b : err_a;
    assign m_busy   = use_b ? busy_b : busy_a;
    assign m_ox     = use_b ? ox_b : ox_a;
    assign m_oy     = use_b ? oy_b : oy_a;
    assign m_count  = use_b ? {12'b0, count_b} : count_a;

    circle_tracer dut (
        .mclock (mclock), .rst_n (rst_n), .start (start), .x0 (x0), .y0 (y0), .r2 (r2),
        .dir (dir), .busy (busy_a), .done (done_a), .err (err_a), .ox (ox_a), .oy (oy_a),
        .ovalid (ovalid_a), .oready (oready), .count (count_a)
    );

    circle_tracer #(.MAX_STEPS(8)) dut8 (
        .mclock (mclock), .rst_n (rst_n), .start (start), .x0 (x0), .y0 (y0), .r2 (r2),
        .dir (dir), .busy (busy_b), .done (done_b), .err (err_b), .ox (ox_b), .oy (oy_b),
        .ovalid (ovalid_b), .oready (oready), .count (count_b)
    );

    always #5 mclock = ~mclock;

    int total = 0;
    int bad   = 0;
    int cap_x[$], cap_y[$], mx[$], my[$], sv_x[$], sv_y[$];
    bit got_done, got_err, merr, mlong;
    int got_count, done_at, first_valid_at;

    typedef struct packed {
        int          x0;
        int          y0;
        longint      r2;
        bit          d;
        bit          b;
        bit          e;
        int          stall;
        int          nfirst;
        logic [0:3][31:0] fx;
        logic [0:3][31:0] fy;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: follow the quadrant rules and min-|error| choice with plain integers.
    task automatic model(input int px, input int py, input longint pr, input bit pd,
                         input int maxs, input int lim);
        int x, y, dx, dy, ax, by, nx, ny;
        longint ea, eb, ec, best;
        mx.delete(); my.delete();
        merr = 0; mlong = 0;
        if (px == 0 && py == 0) begin
            merr = 1;
            return;
        end
        x = px; y = py;
        while (1'b1) begin
            mx.push_back(x); my.push_back(y);
            if (mx.size() > lim) begin mlong = 1; return; end
            if (pd) begin
                if (y > 0 && x >= 0)      begin dx = 1;  dy = -1; end
                else if (x > 0 && y <= 0) begin dx = -1; dy = -1; end
                else if (y < 0 && x <= 0) begin dx = -1; dy = 1;  end
                else                      begin dx = 1;  dy = 1;  end
            end else begin
                if (x > 0 && y >= 0)      begin dx = -1; dy = 1;  end
                else if (x <= 0 && y > 0) begin dx = -1; dy = -1; end
                else if (x < 0 && y <= 0) begin dx = 1;  dy = -1; end
                else                      begin dx = 1;  dy = 1;  end
            end
            ax = x + dx; by = y + dy;
            if (ax < -32768 || ax > 32767 || by < -32768 || by > 32767) begin
                merr = 1;
                return;
            end
            ea = longint'(ax) * ax + longint'(y) * y - pr;
            eb = longint'(ax) * ax + longint'(by) * by - pr;
            ec = longint'(x) * x + longint'(by) * by - pr;
            if (ea < 0) ea = -ea;
            if (eb < 0) eb = -eb;
            if (ec < 0) ec = -ec;
            nx = ax; ny = by; best = eb;
            if (ea < best) begin nx = ax; ny = y; best = ea; end
            if (ec < best) begin nx = x; ny = by; end
            x = nx; y = ny;
            if (x == px && y == py) return;
            if (mx.size() == maxs) begin merr = 1; return; end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && (busy_a || busy_b); i++) @(posedge mclock);
        if (busy_a || busy_b) begin
            total++; bad++;
            $display("FAIL idle_wait: got busy expected idle");
        end
    endtask

    task automatic run_trace(input int px, input int py, input longint pr, input bit pd,
                             input int stall_at, input bit which, input int budget);
        int stall_left;
        bit stalled;
        logic signed [15:0] hx, hy;
        wait_idle();
        use_b = which;
        @(posedge mclock); #1;
        x0 = 16'(px); y0 = 16'(py); r2 = 32'(pr); dir = pd; oready = 1'b1; start = 1'b1;
        @(posedge mclock); #1;
        start = 1'b0;
        cap_x.delete(); cap_y.delete();
        got_done = 0; got_err = 0; got_count = -1; done_at = -1; first_valid_at = -1;
        stall_left = 0; stalled = 0; hx = '0; hy = '0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            if (m_ovalid && first_valid_at < 0) first_valid_at = cyc;
            if (m_done) begin
                got_done = 1; done_at = cyc; got_err = m_err; got_count = int'(m_count);
                chk("busy_at_done", m_busy, 0);
                break;
            end
            if (stall_left > 0) begin
                chk("stall_ovalid", m_ovalid, 1);
                chk("stall_ox", m_ox, hx);
                chk("stall_oy", m_oy, hy);
                stall_left--;
            end else if (m_ovalid && stall_at >= 0 && !stalled && cap_x.size() == stall_at) begin
                stalled = 1; stall_left = 4; hx = m_ox; hy = m_oy;
            end
            oready = (stall_left == 0);
            if (m_ovalid && oready) begin
                cap_x.push_back(int'(m_ox));
                cap_y.push_back(int'(m_oy));
            end
            @(posedge mclock); #1;
        end
        oready = 1'b1;
        if (!got_done) begin
            total++; bad++;
            $display("FAIL trace_timeout: got no done expected done within %0d cycles", budget);
        end
    endtask

    task automatic compare_run(input string nm);
        chk({nm, " done"}, got_done, 1);
        chk({nm, " npts"}, cap_x.size(), mx.size());
        for (int i = 0; i < cap_x.size() && i < mx.size(); i++) begin
            chk({nm, " x"}, cap_x[i], mx[i]);
            chk({nm, " y"}, cap_y[i], my[i]);
        end
        chk({nm, " err"}, got_err, merr);
        chk({nm, " count"}, got_count, mx.size());
    endtask

    initial begin
        int found, rx, ry, st, tries;
        longint rr;
        bit rd;

        repeat (3) @(posedge mclock);
        #1;
        chk("rst_ovalid", ovalid_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_ox", ox_a, 0);
        chk("rst_count", count_a, 0);
        rst_n = 1'b1;
        @(posedge mclock); #1;

        vecs[0] = '{x0: 5, y0: 0, r2: 25, d: 1'b1, b: 1'b0, e: 1'b0, stall: -1, nfirst: 4,
                    fx: '{5, 5, 5, 4}, fy: '{0, -1, -2, -3}};
        vecs[1] = '{x0: 5, y0: 0, r2: 25, d: 1'b0, b: 1'b0, e: 1'b0, stall: -1, nfirst: 4,
                    fx: '{5, 5, 5, 4}, fy: '{0, 1, 2, 3}};
        vecs[2] = '{x0: 5, y0: 0, r2: 25, d: 1'b1, b: 1'b0, e: 1'b0, stall: 7, nfirst: 4,
                    fx: '{5, 5, 5, 4}, fy: '{0, -1, -2, -3}};
        vecs[3] = '{x0: 5, y0: 0, r2: 25, d: 1'b1, b: 1'b1, e: 1'b1, stall: -1, nfirst: 4,
                    fx: '{5, 5, 5, 4}, fy: '{0, -1, -2, -3}};
        vecs[4] = '{x0: 32767, y0: 5, r2: 64'd1073676314, d: 1'b1, b: 1'b0, e: 1'b1,
                    stall: -1, nfirst: 1, fx: '{32767, 0, 0, 0}, fy: '{5, 0, 0, 0}};
        vecs[5] = '{x0: -5, y0: -32768, r2: 64'd1073741849, d: 1'b0, b: 1'b0, e: 1'b1,
                    stall: -1, nfirst: 1, fx: '{-5, 0, 0, 0}, fy: '{-32768, 0, 0, 0}};
        vecs[6] = '{x0: 0, y0: 0, r2: 25, d: 1'b1, b: 1'b0, e: 1'b1, stall: -1, nfirst: 0,
                    fx: '{0, 0, 0, 0}, fy: '{0, 0, 0, 0}};

        for (int v = 0; v < 7; v++) begin
            run_trace(vecs[v].x0, vecs[v].y0, vecs[v].r2, vecs[v].d, vecs[v].stall,
                      vecs[v].b, 3000);
            model(vecs[v].x0, vecs[v].y0, vecs[v].r2, vecs[v].d, vecs[v].b ? 8 : 65535, 5000);
            compare_run($sformatf("vec%0d", v));
            chk($sformatf("vec%0d err_tab", v), got_err, vecs[v].e);
            for (int i = 0; i < vecs[v].nfirst; i++) begin
                if (i < cap_x.size()) begin
                    chk($sformatf("vec%0d first_x%0d", v, i), cap_x[i], int'(vecs[v].fx[i]));
                    chk($sformatf("vec%0d first_y%0d", v, i), cap_y[i], int'(vecs[v].fy[i]));
                end else begin
                    chk($sformatf("vec%0d first_missing", v), cap_x.size(), i + 1);
                end
            end
            if (vecs[v].nfirst == 0) begin
                chk("origin first_valid", first_valid_at, -1);
                chk("origin done_at", done_at, 2);
                chk("origin count", got_count, 0);
            end else begin
                chk($sformatf("vec%0d ovalid_latency", v), first_valid_at, 1);
            end
            if (v == 0) begin
                sv_x = cap_x; sv_y = cap_y;
                chk("cw count_mod4", got_count % 4, 0);
            end
            if (v == 1) begin
                chk("mirror size", cap_x.size(), sv_x.size());
                for (int i = 0; i < sv_x.size(); i++) begin
                    found = 0;
                    for (int j = 0; j < cap_x.size(); j++)
                        if (cap_x[j] == sv_x[i] && cap_y[j] == -sv_y[i]) found = 1;
                    chk("mirror point", found, 1);
                end
            end
            if (v == 2) begin
                chk("stall size", cap_x.size(), sv_x.size());
                for (int i = 0; i < cap_x.size() && i < sv_x.size(); i++) begin
                    chk("stall seq_x", cap_x[i], sv_x[i]);
                    chk("stall seq_y", cap_y[i], sv_y[i]);
                end
            end
            if (v == 3) chk("max_steps npts", cap_x.size(), 8);
        end

        // Abort mid-trace with reset, then restart from a fresh point.
        wait_idle();
        use_b = 1'b0;
        @(posedge mclock); #1;
        x0 = 16'sd5; y0 = 16'sd0; r2 = 32'd25; dir = 1'b1; oready = 1'b1; start = 1'b1;
        @(posedge mclock); #1;
        start = 1'b0;
        for (int i = 0; i < 200 && count_a != 16'd3; i++) begin
            @(posedge mclock); #1;
        end
        chk("pre_reset count", count_a, 3);
        rst_n = 1'b0;
        #1;
        chk("abort ovalid", ovalid_a, 0);
        chk("abort busy", busy_a, 0);
        chk("abort err", err_a, 0);
        chk("abort ox", ox_a, 0);
        chk("abort oy", oy_a, 0);
        chk("abort count", count_a, 0);
        chk("abort count8", count_b, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge mclock); #1;
            chk("abort no_done", done_a, 0);
        end
        rst_n = 1'b1;
        model(0, 7, 49, 1'b0, 65535, 5000);
        run_trace(0, 7, 49, 1'b0, -1, 1'b0, 3000);
        compare_run("restart");
        if (cap_x.size() > 0) begin
            chk("restart first_x", cap_x[0], 0);
            chk("restart first_y", cap_y[0], 7);
        end

        for (int t = 0; t < 16; t++) begin
            tries = 0;
            do begin
                rx = int'($urandom_range(40)) - 20;
                ry = int'($urandom_range(40)) - 20;
                rr = longint'(rx * rx + ry * ry) + longint'($urandom_range(6)) - 3;
                if (rr < 0) rr = 0;
                rd = 1'($urandom_range(1));
                model(rx, ry, rr, rd, 65535, 300);
                tries++;
            end while (mlong && tries < 50);
            if (mlong) continue;
            st = -1;
            if ($urandom_range(1) == 1 && mx.size() > 1) st = int'($urandom_range(mx.size() - 1));
            run_trace(rx, ry, rr, rd, st, 1'b0, mx.size() * 12 + 60);
            compare_run($sformatf("rand%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
